// File: rtl/spectrum_bar_display.sv
// rtl/spectrum_bar_display.sv - VGA spectrum bar renderer with per-bin peak hold/decay and update strobe
module spectrum_bar_display #(
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int N_BINS      = 10,
  parameter int VAL_W       = 12,
  parameter int SHIFT       = 2,
  parameter int GAP         = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 8,
  parameter int PRESC_W     = 16,
  localparam int IDX_W      = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         posx,
  input  logic [9:0]         posy,
  input  logic               frame_start,
  input  logic               peak_en,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [VAL_W-1:0]   freq_value,
  output logic               set_values_flag,
  output logic [IDX_W-1:0]   freq_pos_needed,
  output logic [VAL_W-1:0]   val_out,
  output logic               bar_on,
  output logic               peak_on
);

  localparam int BIN_W  = SCREEN_W / N_BINS;
  localparam int X_END  = N_BINS * BIN_W;
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [31:0] px32, py_in32;
  logic        x_ok, in_range_d, gap_d;

  assign px32       = 32'(posx);
  assign py_in32    = 32'(posy);
  assign x_ok       = px32 < X_END;
  assign in_range_d = x_ok && (py_in32 < SCREEN_H);
  assign gap_d      = (px32 % BIN_W) >= (BIN_W - GAP);

  logic       s1_in_range, s1_gap;
  logic [9:0] s1_posy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in_range     <= 1'b0;
      s1_gap          <= 1'b0;
      s1_posy         <= '0;
      freq_pos_needed <= '0;
    end else begin
      s1_in_range     <= in_range_d;
      s1_gap          <= gap_d;
      s1_posy         <= posy;
      freq_pos_needed <= x_ok ? IDX_W'(px32 / BIN_W) : '0;
    end
  end

  logic [VAL_W-1:0]  peak     [N_BINS];
  logic [HOLD_W-1:0] hold     [N_BINS];
  logic [VAL_W-1:0]  nxt_peak [N_BINS];
  logic [HOLD_W-1:0] nxt_hold [N_BINS];

  logic [31:0] py32, fv_sh, bh, pk_sh, ph;
  logic        bar_d, peak_d;

  // Marker height is read from the stored peak, before this cycle's capture/decay.
  always_comb begin
    py32   = 32'(s1_posy);
    fv_sh  = 32'(freq_value) >> SHIFT;
    bh     = (fv_sh > SCREEN_H) ? SCREEN_H : fv_sh;
    pk_sh  = 32'(peak[freq_pos_needed]) >> SHIFT;
    ph     = (pk_sh > (SCREEN_H - 2)) ? (SCREEN_H - 2) : pk_sh;
    bar_d  = s1_in_range && !s1_gap && (py32 >= (SCREEN_H - bh));
    peak_d = peak_en && s1_in_range && !s1_gap &&
             ((py32 + ph + 2) >= SCREEN_H) && ((py32 + ph) < SCREEN_H);
  end

  // Decay is applied first so a same-cycle capture competes against the decayed value.
  always_comb begin
    for (int b = 0; b < N_BINS; b++) begin
      nxt_peak[b] = peak[b];
      nxt_hold[b] = hold[b];
      if (frame_start) begin
        if (hold[b] < HOLD_W'(HOLD_FRAMES))
          nxt_hold[b] = hold[b] + 1'b1;
        else
          nxt_peak[b] = (peak[b] >= VAL_W'(DECAY)) ? peak[b] - VAL_W'(DECAY) : '0;
      end
      if (s1_in_range && (freq_pos_needed == IDX_W'(b)) && (freq_value > nxt_peak[b])) begin
        nxt_peak[b] = freq_value;
        nxt_hold[b] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BINS; b++) begin
        peak[b] <= '0;
        hold[b] <= '0;
      end
      val_out <= '0;
      bar_on  <= 1'b0;
      peak_on <= 1'b0;
    end else begin
      for (int b = 0; b < N_BINS; b++) begin
        peak[b] <= nxt_peak[b];
        hold[b] <= nxt_hold[b];
      end
      val_out <= freq_value;
      bar_on  <= bar_d;
      peak_on <= peak_d;
    end
  end

  logic [PRESC_W-1:0] presc_cnt;

  // Compare with >= so lowering the period below the live count fires immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt       <= '0;
      set_values_flag <= 1'b0;
    end else if (presc_cnt >= prescaler) begin
      presc_cnt       <= '0;
      set_values_flag <= 1'b1;
    end else begin
      presc_cnt       <= presc_cnt + 1'b1;
      set_values_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spectrum_bar_display.sv
// tb/tb_spectrum_bar_display.sv - randomized and directed checks of spectrum_bar_display against a behavioural model
module tb_spectrum_bar_display;
  localparam int W = 800, H = 600, NB = 10, VW = 12, SH = 2, GAP = 4;
  localparam int HF = 30, DEC = 8, PW = 16;
  localparam int BW = W / NB;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    posx, posy;
  logic          frame_start, peak_en;
  logic [PW-1:0] prescaler;
  logic [VW-1:0] freq_value;
  logic          set_values_flag;
  logic [3:0]    freq_pos_needed;
  logic [VW-1:0] val_out;
  logic          bar_on, peak_on;
  logic [VW-1:0] energy [NB];

  assign freq_value = energy[freq_pos_needed];

  spectrum_bar_display dut (
    .clk(clk), .rst(rst), .posx(posx), .posy(posy), .frame_start(frame_start),
    .peak_en(peak_en), .prescaler(prescaler), .freq_value(freq_value),
    .set_values_flag(set_values_flag), .freq_pos_needed(freq_pos_needed),
    .val_out(val_out), .bar_on(bar_on), .peak_on(peak_on)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int m_inr, m_bin, m_gap, m_py, m_cnt;
  int e_val, e_bar, e_pk, e_flag, e_bin;
  int mpk [NB];
  int mhd [NB];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inr = 0; m_bin = 0; m_gap = 0; m_py = 0; m_cnt = 0;
    e_val = 0; e_bar = 0; e_pk = 0; e_flag = 0; e_bin = 0;
    for (int b = 0; b < NB; b++) begin mpk[b] = 0; mhd[b] = 0; end
  endtask

  task automatic step(input int x, input int y, input bit fs);
    int fv, bh, ph;
    posx = 10'(x); posy = 10'(y); frame_start = fs;
    fv = int'(energy[m_bin]);
    bh = fv >> SH; if (bh > H) bh = H;
    ph = mpk[m_bin] >> SH; if (ph > H - 2) ph = H - 2;
    e_val = fv;
    e_bar = (m_inr != 0 && m_gap == 0 && m_py >= H - bh) ? 1 : 0;
    e_pk  = (peak_en && m_inr != 0 && m_gap == 0 && m_py >= H - ph - 2 && m_py < H - ph) ? 1 : 0;
    if (fs) begin
      for (int b = 0; b < NB; b++) begin
        if (mhd[b] < HF) mhd[b]++;
        else mpk[b] = (mpk[b] > DEC) ? mpk[b] - DEC : 0;
      end
    end
    if (m_inr != 0 && fv > mpk[m_bin]) begin mpk[m_bin] = fv; mhd[m_bin] = 0; end
    m_inr = (x < NB * BW && y < H) ? 1 : 0;
    m_bin = (x < NB * BW) ? x / BW : 0;
    m_gap = ((x % BW) >= BW - GAP) ? 1 : 0;
    m_py  = y;
    e_bin = m_bin;
    if (m_cnt >= int'(prescaler)) begin e_flag = 1; m_cnt = 0; end
    else begin e_flag = 0; m_cnt++; end
    @(posedge clk); @(negedge clk);
    check("val_out", int'(val_out), e_val);
    check("bar_on", int'(bar_on), e_bar);
    check("peak_on", int'(peak_on), e_pk);
    check("flag", int'(set_values_flag), e_flag);
    check("bin", int'(freq_pos_needed), e_bin);
  endtask

  task automatic look(input int x, input int y);
    step(x, y, 1'b0);
    step(1023, 0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1023, 0, 1'b1);
  endtask

  initial begin
    int xs [6] = '{0, 79, 80, 799, 800, 1023};
    int eb [6] = '{0, 0, 1, 9, 0, 0};
    int ebar [6] = '{1, 0, 1, 0, 0, 0};
    rst = 1'b1; posx = '0; posy = '0; frame_start = 1'b0; peak_en = 1'b1; prescaler = 16'd3;
    for (int b = 0; b < NB; b++) energy[b] = '0;
    model_reset();
    #12;
    check("rst_val", int'(val_out), 0);
    check("rst_bar", int'(bar_on), 0);
    check("rst_peak", int'(peak_on), 0);
    check("rst_flag", int'(set_values_flag), 0);
    check("rst_bin", int'(freq_pos_needed), 0);
    @(negedge clk); rst = 1'b0;

    // prescaler period, lowering below the live count, continuous strobe
    for (int c = 1; c <= 14; c++) begin
      step(1023, 0, 1'b0);
      if (c <= 12) check("presc3", int'(set_values_flag), (c % 4 == 0) ? 1 : 0);
    end
    prescaler = 16'd1;
    step(1023, 0, 1'b0);
    check("presc_lower", int'(set_values_flag), 1);
    prescaler = 16'd0;
    for (int c = 0; c < 3; c++) begin
      step(1023, 0, 1'b0);
      check("presc0", int'(set_values_flag), 1);
    end
    prescaler = 16'd7;

    // bin mapping and out-of-range blanking
    for (int b = 0; b < NB; b++) energy[b] = 12'd4000;
    for (int i = 0; i < 6; i++) begin
      step(xs[i], 300, 1'b0);
      check("map_bin", int'(freq_pos_needed), eb[i]);
      step(1023, 0, 1'b0);
      check("map_bar", int'(bar_on), ebar[i]);
    end
    for (int b = 0; b < NB; b++) energy[b] = '0;

    // bar height 100 rows and right-edge gap
    energy[0] = 12'd400;
    look(10, 499); check("bar_499", int'(bar_on), 0);
    look(10, 500); check("bar_500", int'(bar_on), 1);
    look(10, 599); check("bar_599", int'(bar_on), 1);
    look(75, 599); check("bar_75", int'(bar_on), 1);
    for (int x = 76; x < 80; x++) begin
      look(x, 599); check("bar_gap", int'(bar_on), 0);
    end
    energy[0] = '0;

    // peak hold then decay to zero on bin 3
    energy[3] = 12'd800; look(240, 0); energy[3] = '0;
    look(241, 398); check("pk800_398", int'(peak_on), 1);
    look(241, 397); check("pk800_397", int'(peak_on), 0);
    frames(30);
    look(241, 399); check("pk_held", int'(peak_on), 1);
    frames(1);
    look(241, 399); check("pk792_399", int'(peak_on), 0);
    look(241, 401); check("pk792_401", int'(peak_on), 1);
    frames(110);
    look(241, 598); check("pk0_598", int'(peak_on), 1);
    look(241, 597); check("pk0_597", int'(peak_on), 0);

    // capture coinciding with decay on bin 2
    energy[2] = 12'd608; look(160, 0); energy[2] = '0;
    frames(30);
    energy[2] = 12'd500; step(160, 0, 1'b0); step(1023, 0, 1'b1); energy[2] = '0;
    frames(1);
    look(161, 450); check("cap_lose", int'(peak_on), 1);
    energy[2] = 12'd700; step(160, 0, 1'b0); step(1023, 0, 1'b1); energy[2] = '0;
    frames(1);
    look(161, 423); check("cap_win", int'(peak_on), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) energy[$urandom_range(0, NB - 1)] = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) peak_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) prescaler = 16'($urandom_range(0, 9));
      step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 639)), ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-frame
    rst = 1'b1; prescaler = 16'd5; peak_en = 1'b1;
    #1;
    check("mid_rst_val", int'(val_out), 0);
    check("mid_rst_bar", int'(bar_on), 0);
    check("mid_rst_peak", int'(peak_on), 0);
    check("mid_rst_flag", int'(set_values_flag), 0);
    check("mid_rst_bin", int'(freq_pos_needed), 0);
    model_reset();
    for (int b = 0; b < NB; b++) energy[b] = '0;
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step(1023, 0, 1'b0);
      check("rst_presc", int'(set_values_flag), (c == 6) ? 1 : 0);
    end
    for (int b = 0; b < NB; b++) begin
      look(b * BW + 1, 598); check("rst_pk_598", int'(peak_on), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spectrum_bar_display.md
# spectrum_bar_display

Parametrised successor to the 10-bin FFT bar display. It maps the current VGA pixel position to a frequency bin, requests that bin's energy from the power calculator, and produces registered pixel-enable outputs for the bar and for a per-bin peak-hold marker with frame-based hold and decay. It sits between the VGA timing generator and the band-power calculator, and also generates the prescaled update strobe for that calculator.

## Interface
Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- N_BINS, 10, number of frequency bins (1..64)
- VAL_W, 12, energy value width
- SHIFT, 2, right shift from energy value to bar height in pixels
- GAP, 4, blank columns at the right edge of each bin (less than BIN_W)
- HOLD_FRAMES, 30, frames a new peak is held before decay starts
- DECAY, 8, energy units subtracted from a peak per frame after hold expires
- PRESC_W, 16, prescaler width

Derived: BIN_W = SCREEN_W / N_BINS (integer division). IDX_W = clog2(N_BINS), minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- posx  in  10  current pixel column
- posy  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at the start of each frame
- peak_en  in  1  enables the peak marker output
- prescaler  in  PRESC_W  strobe period minus one
- freq_value  in  VAL_W  energy of bin freq_pos_needed, valid in the same cycle
- set_values_flag  out  1  update strobe to the power calculator
- freq_pos_needed  out  IDX_W  bin requested
- val_out  out  VAL_W  registered energy of the bin being drawn
- bar_on  out  1  bar pixel enable
- peak_on  out  1  peak-marker pixel enable

## Operation
- Stage 1 (registered from posx/posy):
  - in_range = posx < N_BINS*BIN_W and posy < SCREEN_H.
  - freq_pos_needed = posx / BIN_W, or 0 when posx is out of range.
  - gap_col = (posx mod BIN_W) >= BIN_W - GAP.
  - posy is delayed alongside these signals.
- Stage 2 (registered from stage 1 and freq_value):
  - val_out = freq_value.
  - bh = min(freq_value >> SHIFT, SCREEN_H).
  - bar_on = in_range & ~gap_col & (posy >= SCREEN_H - bh).
  - ph = min(peak[bin] >> SHIFT, SCREEN_H - 2).
  - peak_on = peak_en & in_range & ~gap_col & (SCREEN_H - ph - 2 <= posy < SCREEN_H - ph).
  - peak_on reads the stored peak before any update made in the same cycle.
- Peak capture happens at stage 2, only when in_range:
  - if freq_value > peak[bin]: peak[bin] = freq_value and hold[bin] = 0.
- Decay happens on frame_start, for all bins in parallel:
  - if hold[b] < HOLD_FRAMES: hold[b] increments.
  - otherwise: peak[b] = saturating peak[b] - DECAY (floor 0).
- Capture and decay in the same cycle on the same bin:
  - peak = max(freq_value, decayed value).
  - hold resets only if freq_value wins.
- Prescaler behaviour:
  - The counter increments every clk.
  - When counter >= prescaler: set_values_flag = 1 for one cycle and counter = 0.
  - Otherwise set_values_flag = 0.
  - prescaler = 0 gives a continuous strobe.
  - Lowering prescaler below the current count fires on the next cycle; there is no wrap.

## Timing
- Reset (asynchronous) clears to 0: all outputs, the counter, the stage registers, every peak[] and every hold[].
- Latency:
  - posx to freq_pos_needed: 1 clk.
  - posx/posy to bar_on, peak_on and val_out: 2 clk.
  - The VGA side delays its sync signals by 2 clk to match.
- freq_value must be valid combinationally in the cycle freq_pos_needed is presented (asynchronous read from the calculator).
- First set_values_flag after reset release occurs at cycle prescaler+1. After that the period is prescaler+1 cycles.
- A reset asserted mid-frame clears everything. Peaks rebuild from zero with no partial state.

## Test plan
- Bin mapping with defaults. Stimulus: posx = 0, 79, 80, 799, 800, 1023. Required: freq_pos_needed = 0, 0, 1, 9, 0, 0 one clk later; bar_on = 0 for 800 and 1023 regardless of freq_value.
- Bar height and gap. Stimulus: freq_value = 400 (bh = 100). Required: bar_on = 1 at posy 500..599 and 0 at posy 499. bar_on = 0 at posx 76..79 (gap), 2 clk latency.
- Peak hold and decay. Stimulus: feed 800 to bin 3, then 0. Required: peak stays 800 for 30 frame_start pulses, then drops 792, 784, ... to 0 with no underflow. peak_on rows are 398..399 while peak = 800.
- Capture during decay. Stimulus: feed 500 to bin 2 on a frame_start cycle where the decayed peak is 600. Required: peak = 600 and hold is not reset. Repeating with 700 gives peak = 700 and hold = 0.
- Prescaler. Stimulus: prescaler = 3. Required: flag at cycles 4, 8, 12. Changing to 1 while the count is 2 gives a flag on the next cycle. prescaler = 0 gives the flag held high.
- Reset mid-operation. Stimulus: assert rst mid-frame with peaks nonzero. Required: all outputs, peaks and counter are 0 immediately (without waiting for a clock edge).
